// File: rtl/frame_capture_ctrl.sv
// OV7670 pixel-bus capture sequencer: pairs bytes into RGB565 pixels and
// drives the frame buffer write port with x/y coordinates.
module frame_capture_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        captureEn,
    input  logic        continuous,
    input  logic        vsync,
    input  logic        href,
    input  logic [7:0]  dataIn,
    output logic [15:0] pixelOut,
    output logic [9:0]  outX,
    output logic [8:0]  outY,
    output logic        writeEn,
    output logic        frameDone,
    output logic        busy,
    output logic [7:0]  frameCount,
    output logic        lineErr
);

    localparam logic [9:0] H_LIM = 10'(H_ACTIVE);
    localparam logic [8:0] V_LIM = 9'(V_ACTIVE);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t      state_q;
    logic        vs_q, vs2_q, hr_q, hr2_q;
    logic [7:0]  din_q, hi_q;
    logic        sel_q;
    logic [9:0]  x_q, x_d;
    logic [8:0]  y_q, y_d;
    logic [15:0] pix_q;
    logic [9:0]  ox_q;
    logic [8:0]  oy_q;
    logic        we_q, done_q, err_q;
    logic [7:0]  cnt_q;

    logic vs_rise, vs_fall, hr_fall, in_win;

    assign vs_rise = vs_q & ~vs2_q;
    assign vs_fall = ~vs_q & vs2_q;
    assign hr_fall = ~hr_q & hr2_q;
    assign in_win  = (x_q < H_LIM) && (y_q < V_LIM);

    // Saturating counters keep off-window pixels from wrapping onto (0,0).
    assign x_d = (x_q == 10'h3FF) ? x_q : x_q + 10'd1;
    assign y_d = (y_q == 9'h1FF) ? y_q : y_q + 9'd1;

    assign pixelOut   = pix_q;
    assign outX       = ox_q;
    assign outY       = oy_q;
    assign writeEn    = we_q;
    assign frameDone  = done_q;
    assign busy       = (state_q != IDLE);
    assign frameCount = cnt_q;
    assign lineErr    = err_q;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            vs_q    <= 1'b0;
            vs2_q   <= 1'b0;
            hr_q    <= 1'b0;
            hr2_q   <= 1'b0;
            din_q   <= '0;
            hi_q    <= '0;
            sel_q   <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            pix_q   <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            vs_q   <= vsync;
            vs2_q  <= vs_q;
            hr_q   <= href;
            hr2_q  <= hr_q;
            din_q  <= dataIn;
            we_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (captureEn) begin
                        state_q <= ARM;
                        err_q   <= 1'b0;
                    end
                end
                ARM: begin
                    if (!captureEn) begin
                        state_q <= IDLE;
                    end else if (vs_fall) begin
                        state_q <= CAPTURE;
                        x_q     <= '0;
                        y_q     <= '0;
                        sel_q   <= 1'b0;
                    end
                end
                CAPTURE: begin
                    // Frame end wins over a coincident line end.
                    if (vs_rise) begin
                        done_q <= 1'b1;
                        cnt_q  <= cnt_q + 8'd1;
                        sel_q  <= 1'b0;
                        if (hr_fall && sel_q) err_q <= 1'b1;
                        state_q <= (continuous && captureEn) ? ARM : IDLE;
                    end else if (hr_fall) begin
                        if (sel_q) err_q <= 1'b1;
                        sel_q <= 1'b0;
                        x_q   <= '0;
                        if (x_q != '0) y_q <= y_d;
                    end else if (hr_q) begin
                        if (!sel_q) begin
                            hi_q  <= din_q;
                            sel_q <= 1'b1;
                        end else begin
                            sel_q <= 1'b0;
                            x_q   <= x_d;
                            if (in_win) begin
                                pix_q <= {hi_q, din_q};
                                ox_q  <= x_q;
                                oy_q  <= y_q;
                                we_q  <= 1'b1;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
